// File: rtl/ifetch_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: FSM encoding,
// default fetch addresses and the word-address increment.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [29:0] DEF_RESET_PC   = 30'h0000_0000;
    localparam logic [29:0] DEF_EXC_VECTOR = 30'h0000_0060;

    // Word addresses wrap at the top of the 30-bit space.
    function automatic logic [29:0] pc_inc(input logic [29:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/ifetch_unit_npc.sv
// Next-PC priority mux for instruction fetch: exception/eret first,
// then branch redirect, otherwise the sequential successor.
module ifetch_npc
    import ifetch_pkg::*;
#(
    parameter logic [29:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [29:0] fetch_pc,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_target,
    input  logic        exc_valid,
    input  logic [29:0] exc_target,
    input  logic        exc_is_eret,
    output logic        take,
    output logic [29:0] next_pc
);

    always_comb begin
        take    = exc_valid | redirect_valid;
        next_pc = pc_inc(fetch_pc);
        if (exc_valid) begin
            next_pc = exc_is_eret ? exc_target : EXC_VECTOR;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: single-outstanding memory request FSM feeding a
// one-entry buffer that drives the IF/ID register.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [29:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [29:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        BranchBubble,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_target,
    input  logic        exc_valid,
    input  logic [29:0] exc_target,
    input  logic        exc_is_eret,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_ins,
    output logic [29:0] pc_plus_4,
    output logic        flush
);

    fetch_state_t state, state_nxt;
    logic [29:0]  fetch_pc, fetch_pc_nxt;
    logic         buf_valid, buf_valid_nxt;
    logic [31:0]  buf_ins, buf_ins_nxt;
    logic [29:0]  buf_pc4, buf_pc4_nxt;

    logic         stall;
    logic         take;
    logic [29:0]  next_pc;

    assign stall     = hazard | BranchBubble;
    assign imem_addr = fetch_pc;
    assign if_ins    = buf_ins;
    assign pc_plus_4 = buf_pc4;
    assign flush     = ~buf_valid | redirect_valid | exc_valid;

    ifetch_npc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc (
        .fetch_pc        (fetch_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .exc_target      (exc_target),
        .exc_is_eret     (exc_is_eret),
        .take            (take),
        .next_pc         (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RST;
            fetch_pc  <= RESET_PC;
            buf_valid <= 1'b0;
            buf_ins   <= 32'd0;
            buf_pc4   <= 30'd0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            buf_valid <= buf_valid_nxt;
            buf_ins   <= buf_ins_nxt;
            buf_pc4   <= buf_pc4_nxt;
        end
    end

    // The buffer is consumed whenever it is valid and the decoder is not
    // stalled; a request may only go out once the slot is free that cycle.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        buf_valid_nxt = buf_valid & stall;
        buf_ins_nxt   = buf_ins;
        buf_pc4_nxt   = buf_pc4;
        imem_req      = 1'b0;

        case (state)
            ST_RST: begin
                if (take) begin
                    fetch_pc_nxt = next_pc;
                end
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (take) begin
                    fetch_pc_nxt = next_pc;
                end else if (~buf_valid | ~stall) begin
                    imem_req  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (take) begin
                    fetch_pc_nxt = next_pc;
                    state_nxt    = imem_ack ? ST_REQ : ST_DRAIN;
                end else if (imem_ack) begin
                    buf_valid_nxt = 1'b1;
                    buf_ins_nxt   = imem_rdata;
                    buf_pc4_nxt   = next_pc;
                    fetch_pc_nxt  = next_pc;
                    state_nxt     = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The response still in flight belongs to the old path.
                if (take) begin
                    fetch_pc_nxt = next_pc;
                end
                if (imem_ack) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase

        if (take) begin
            buf_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_ifetch_unit;

    localparam logic [29:0] MAIN_RESET_PC = 30'h0000_0000;
    localparam logic [29:0] WRAP_RESET_PC = 30'h3FFF_FFFF;
    localparam logic [29:0] EXCV          = 30'h0000_0060;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard;
    logic        BranchBubble;
    logic        redirect_valid;
    logic [29:0] redirect_target;
    logic        exc_valid;
    logic [29:0] exc_target;
    logic        exc_is_eret;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_ins;
    logic [29:0] pc_plus_4;
    logic        flush;

    logic        w_req;
    logic [29:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_ins;
    logic [29:0] w_pc4;
    logic        w_flush;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC   (MAIN_RESET_PC),
        .EXC_VECTOR (EXCV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard          (hazard),
        .BranchBubble    (BranchBubble),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .exc_target      (exc_target),
        .exc_is_eret     (exc_is_eret),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_ins          (if_ins),
        .pc_plus_4       (pc_plus_4),
        .flush           (flush)
    );

    ifetch_unit #(
        .RESET_PC   (WRAP_RESET_PC),
        .EXC_VECTOR (EXCV)
    ) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .hazard          (hazard),
        .BranchBubble    (BranchBubble),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .exc_target      (exc_target),
        .exc_is_eret     (exc_is_eret),
        .imem_req        (w_req),
        .imem_addr       (w_addr),
        .imem_ack        (w_ack),
        .imem_rdata      (w_rdata),
        .if_ins          (w_ins),
        .pc_plus_4       (w_pc4),
        .flush           (w_flush)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Instruction memory: one response slot with a programmable latency.
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [29:0] mem_addr = 30'd0;
    int          mem_lat  = 0;
    logic        mem_hash = 1'b0;
    logic        w_busy   = 1'b0;
    logic [29:0] w_addr_q = 30'd0;

    // Reference model: fetch address, one outstanding request (possibly
    // stale after a redirect) and the presented instruction slot.
    logic        m_valid   = 1'b0;
    logic        m_started = 1'b0;
    logic        m_pend    = 1'b0;
    logic        m_stale   = 1'b0;
    logic [29:0] m_pc      = 30'd0;
    logic        m_bv      = 1'b0;
    logic [31:0] m_ins     = 32'd0;
    logic [29:0] m_pc4     = 30'd0;

    function automatic logic [31:0] mem_word(input logic [29:0] a, input logic hashed);
        return hashed ? ({a, 2'b11} ^ 32'h9E37_79B9) : {2'b00, a};
    endfunction

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic stall, take, e_req;
        if (m_valid) begin
            stall = hazard | BranchBubble;
            take  = redirect_valid | exc_valid;
            e_req = m_started && !m_pend && !take && (!m_bv || !stall);
            expect_val("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            if (e_req) expect_val("imem_addr", {2'b00, imem_addr}, {2'b00, m_pc});
            expect_val("flush", {31'd0, flush}, {31'd0, (!m_bv || take)});
            expect_val("if_ins", if_ins, m_ins);
            expect_val("pc_plus_4", {2'b00, pc_plus_4}, {2'b00, m_pc4});
        end
    endtask

    task automatic applyStimulus(input logic hz, input logic bb, input logic rv,
                                 input logic [29:0] rt, input logic ev,
                                 input logic [29:0] et, input logic eret, input logic rs);
        rst             = rs;
        hazard          = hz;
        BranchBubble    = bb;
        redirect_valid  = rv;
        redirect_target = rt;
        exc_valid       = ev;
        exc_target      = et;
        exc_is_eret     = eret;
        if (mem_busy && mem_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(mem_addr, mem_hash);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        w_ack   = w_busy;
        w_rdata = {2'b00, w_addr_q};
        #3;
        checkOutput();
    endtask

    task automatic idle(input logic hz);
        applyStimulus(hz, 1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 1'b0);
    endtask

    task automatic advance();
        logic stall, take, e_req, got;
        logic [29:0] npc;
        if (rst) begin
            m_valid   = 1'b1;
            m_started = 1'b0;
            m_pend    = 1'b0;
            m_stale   = 1'b0;
            m_pc      = MAIN_RESET_PC;
            m_bv      = 1'b0;
            m_ins     = 32'd0;
            m_pc4     = 30'd0;
        end else if (m_valid) begin
            stall = hazard | BranchBubble;
            take  = redirect_valid | exc_valid;
            e_req = m_started && !m_pend && !take && (!m_bv || !stall);
            npc   = exc_valid ? (exc_is_eret ? exc_target : EXCV) : redirect_target;
            got   = m_pend && imem_ack;
            if (m_bv && !stall) m_bv = 1'b0;
            if (got) begin
                if (!m_stale && !take) begin
                    m_bv  = 1'b1;
                    m_ins = imem_rdata;
                    m_pc4 = m_pc + 30'd1;
                    m_pc  = m_pc + 30'd1;
                end
                m_pend = 1'b0;
            end
            if (take) begin
                m_bv = 1'b0;
                m_pc = npc;
                if (m_pend) m_stale = 1'b1;
            end
            if (e_req) begin
                m_pend  = 1'b1;
                m_stale = 1'b0;
            end
            m_started = 1'b1;
        end
        if (imem_ack) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = mem_lat;
        end
        w_busy   = w_req;
        w_addr_q = w_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [29:0] rt, et;
        // Reset for two cycles, zero-wait memory returning word = address.
        applyStimulus(0, 0, 0, 30'd0, 0, 30'd0, 0, 1'b1); advance();
        applyStimulus(0, 0, 0, 30'd0, 0, 30'd0, 0, 1'b1); advance();
        cyc = 0;
        idle(0);
        expect_val("rst_req", {31'd0, imem_req}, 32'd0);
        expect_val("rst_flush", {31'd0, flush}, 32'd1);
        advance();
        idle(0);
        expect_val("first_req", {31'd0, imem_req}, 32'd1);
        expect_val("first_addr", {2'b00, imem_addr}, 32'd0);
        expect_val("wrap_first_addr", {2'b00, w_addr}, 32'h3FFF_FFFF);
        advance();
        idle(0); advance();
        idle(0);
        expect_val("first_ins", if_ins, 32'd0);
        expect_val("first_pc4", {2'b00, pc_plus_4}, 32'd1);
        expect_val("second_addr", {2'b00, imem_addr}, 32'd1);
        expect_val("wrap_pc4", {2'b00, w_pc4}, 32'd0);
        expect_val("wrap_second_req", {31'd0, w_req}, 32'd1);
        expect_val("wrap_second_addr", {2'b00, w_addr}, 32'd0);
        advance();
        idle(0); advance();
        idle(0);
        expect_val("third_addr", {2'b00, imem_addr}, 32'd2);
        advance();
        idle(0); advance();

        // Decode stall holds the presented instruction for three cycles.
        for (int i = 0; i < 3; i++) begin
            idle(1);
            expect_val("hold_ins", if_ins, 32'd2);
            expect_val("hold_pc4", {2'b00, pc_plus_4}, 32'd3);
            expect_val("hold_req", {31'd0, imem_req}, 32'd0);
            expect_val("hold_flush", {31'd0, flush}, 32'd0);
            advance();
        end
        idle(0);
        expect_val("resume_req", {31'd0, imem_req}, 32'd1);
        expect_val("resume_addr", {2'b00, imem_addr}, 32'd3);
        mem_lat = 2;
        advance();

        // Redirect while waiting; the late response must be dropped.
        applyStimulus(0, 0, 1, 30'h100, 0, 30'd0, 0, 0);
        expect_val("redir_flush", {31'd0, flush}, 32'd1);
        mem_lat = 0;
        advance();
        for (int i = 0; i < 2; i++) begin
            idle(0);
            expect_val("drain_req", {31'd0, imem_req}, 32'd0);
            expect_val("drain_flush", {31'd0, flush}, 32'd1);
            advance();
        end
        idle(0);
        expect_val("redir_addr", {2'b00, imem_addr}, 32'h100);
        expect_val("redir_req", {31'd0, imem_req}, 32'd1);
        advance();
        idle(0); advance();
        idle(0);
        expect_val("redir_ins", if_ins, 32'h100);
        expect_val("redir_pc4", {2'b00, pc_plus_4}, 32'h101);
        expect_val("redir_done_flush", {31'd0, flush}, 32'd0);
        advance();

        // Ack, branch redirect and exception all in one cycle.
        applyStimulus(0, 0, 1, 30'h200, 1, 30'h3ABC, 0, 0);
        advance();
        idle(0);
        expect_val("exc_addr", {2'b00, imem_addr}, 32'h60);
        expect_val("exc_ins_kept", if_ins, 32'h100);
        advance();
        idle(0); advance();
        idle(0);
        expect_val("exc_ins", if_ins, 32'h60);
        mem_lat = 1;
        advance();

        // Reset while waiting, response arrives in the first RST cycle.
        applyStimulus(0, 0, 0, 30'd0, 0, 30'd0, 0, 1'b1);
        mem_lat = 0;
        advance();
        idle(0);
        expect_val("rstw_req", {31'd0, imem_req}, 32'd0);
        expect_val("rstw_ins", if_ins, 32'd0);
        expect_val("rstw_flush", {31'd0, flush}, 32'd1);
        advance();
        idle(0);
        expect_val("rstw_addr", {2'b00, imem_addr}, 32'd0);
        advance();
        idle(0); advance();
        idle(0);
        expect_val("rstw_pc4", {2'b00, pc_plus_4}, 32'd1);
        advance();

        // Randomized traffic against the model.
        mem_hash = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rt = (($urandom % 8) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
            et = 30'($urandom);
            applyStimulus(($urandom % 100) < 25, ($urandom % 100) < 10,
                          ($urandom % 100) < 7, rt, ($urandom % 100) < 3, et,
                          1'($urandom), ($urandom % 100) < 1);
            mem_lat = int'($urandom % 4);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
